hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Pipeline hazard control for the 5-stage MIPS core. It detects register dependences that the EX-stage forwarding mux cannot resolve: load-use, and branches resolved in ID whose operands are still in flight. It drives the stall and bubble controls into PC, IF/ID and ID/EX, and flushes IF/ID on a taken branch. It sits beside the ID stage and complements the EX forwarding logic: forwarding consumes in-flight results, and this block holds the pipeline until those results can be consumed.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- IfIdRs  in  5  rs field of the instruction in ID
- IfIdRt  in  5  rt field of the instruction in ID
- IfIdUsesRt  in  1  instruction in ID reads rt (R-type, store, beq/bne)
- IfIdBranch  in  1  instruction in ID is beq/bne, compared in ID
- IdExMemRead  in  1  instruction in EX is a load
- IdExRegWrite  in  1  instruction in EX writes a register
- IdExRd  in  5  destination register of the instruction in EX
- ExMemMemRead  in  1  instruction in MEM is a load
- ExMemRd  in  5  destination register of the instruction in MEM
- BranchTaken  in  1  ID branch comparator result, valid only when not stalling
- PcWrite  out  1  1 = PC advances
- IfIdWrite  out  1  1 = IF/ID register loads
- IfIdFlush  out  1  1 = IF/ID loads a NOP
- IdExBubble  out  1  1 = ID/EX control bits are zeroed

## Operation
- Match rule: a source register matches a destination when the two are equal and the destination is not 5'd0. The rt source is checked only when IfIdUsesRt=1.
- Required bubble count N is computed combinationally, and the largest applicable value is taken:
  - Load-use: IdExMemRead and the EX destination matches rs or rt gives N=1.
  - Branch after ALU op: IfIdBranch, IdExRegWrite, not IdExMemRead, and the EX destination matches gives N=1.
  - Branch after load in EX: IfIdBranch, IdExMemRead, and the EX destination matches gives N=2.
  - Branch after load in MEM: IfIdBranch, ExMemMemRead, and the MEM destination matches gives N=1.
- FSM states are RUN and HOLD.
  - RUN with N=0: PcWrite=1, IfIdWrite=1, IdExBubble=0, and the FSM stays in RUN.
  - RUN with N≥1: stall this cycle (PcWrite=0, IfIdWrite=0, IdExBubble=1). The FSM goes to HOLD if N=2 and stays in RUN if N=1.
  - HOLD: stall unconditionally for one cycle, then go to RUN. Detection results are ignored in HOLD.
- Flush: IfIdFlush = IfIdBranch & BranchTaken & (state==RUN) & (N==0). A stall always suppresses the flush, because the comparator operands are not yet valid.
- Stall and flush are never asserted together.
- While rst=1, all outputs are forced to PcWrite=0, IfIdWrite=0, IdExBubble=1, IfIdFlush=1, and the FSM is driven to RUN on the edge.

## Timing
- Stall outputs are combinational from the inputs in RUN, with zero-cycle latency. In HOLD they depend only on the registered state.
- The first cycle after rst deasserts is in RUN, with outputs computed from the live inputs.
- Load followed by a dependent branch produces exactly 2 consecutive stall cycles. The MEM-stage load rule re-detects on the second cycle; both paths must agree, and the FSM guarantees the count.
- If rst asserts in HOLD, the reset outputs apply and the next state is RUN. The remaining stall cycle is abandoned.
- Register 0 as the destination never causes a stall.

## Configuration
- HAZARD_PERF_EN defined: adds the outputs StallCycles (out, 16 bits) and FlushCount (out, 16 bits).
  - StallCycles increments on every cycle with PcWrite=0 and rst=0.
  - FlushCount increments on every cycle with IfIdFlush=1 and rst=0.
  - Both counters saturate at 16'hFFFF and clear on rst.
- HAZARD_PERF_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package mips_pipe_pkg holds:
  - the state typedef (RUN, HOLD)
  - the REG_ZERO constant (5'd0)
  - the bubble-count width constant
- Sub-module hazard_match: a 5-bit source/destination comparator with the zero-register guard and an enable input. Four instances are used: rs/EX, rt/EX, rs/MEM, rt/MEM.

## Test plan
- lw $2 in EX (IdExMemRead=1, IdExRd=2); add $3,$2,$4 in ID (IfIdRs=2) -> exactly one cycle of PcWrite=0, IfIdWrite=0, IdExBubble=1, then RUN.
- lw $5 in EX; beq $5,$1 in ID -> two stall cycles: the FSM passes RUN→HOLD→RUN with ExMemMemRead=1, ExMemRd=5 on the second cycle. IfIdFlush=0 during both stall cycles.
- add $7 in EX (IdExRegWrite=1, IdExMemRead=0, IdExRd=7); beq $7 in ID -> one stall. Next cycle BranchTaken=1 -> IfIdFlush=1 for one cycle.
- IdExMemRead=1, IdExRd=0, IfIdRs=0 -> no stall; PcWrite stays 1.
- IfIdUsesRt=0, IfIdRt=9, lw $9 in EX -> no stall. Same stimulus with IfIdUsesRt=1 -> one stall.
- rst asserted during HOLD -> outputs 0/0/1/1 that cycle, state RUN afterwards. With HAZARD_PERF_EN: StallCycles=0 after reset and 2 after the load-branch scenario.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: hazard FSM states,
// the hardwired zero register and the bubble-count width.
package mips_pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         BUBBLE_W = 2;

endpackage

// File: rtl/hazard_match.sv
// Source/destination register comparator. Register 0 as the destination is
// never a dependence because writes to it are discarded.
module hazard_match
  import mips_pipe_pkg::*;
(
  input  logic       en,
  input  logic [4:0] src,
  input  logic [4:0] dst,
  output logic       hit
);

  assign hit = en && (src == dst) && (dst != REG_ZERO);

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard control: load-use and ID-resolved branch stalls, plus the
// IF/ID flush on a taken branch. Optional counters under HAZARD_PERF_EN.
module hazard_stall_unit
  import mips_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IfIdRs,
  input  logic [4:0] IfIdRt,
  input  logic       IfIdUsesRt,
  input  logic       IfIdBranch,
  input  logic       IdExMemRead,
  input  logic       IdExRegWrite,
  input  logic [4:0] IdExRd,
  input  logic       ExMemMemRead,
  input  logic [4:0] ExMemRd,
  input  logic       BranchTaken,
  output logic       PcWrite,
  output logic       IfIdWrite,
  output logic       IfIdFlush,
  output logic       IdExBubble
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
`endif
);

  hz_state_e           state_q;
  logic                rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic                ex_hit, mem_hit;
  logic [BUBBLE_W-1:0] need_bubbles;

  hazard_match u_rs_ex  (.en(1'b1),       .src(IfIdRs), .dst(IdExRd),  .hit(rs_ex_hit));
  hazard_match u_rt_ex  (.en(IfIdUsesRt), .src(IfIdRt), .dst(IdExRd),  .hit(rt_ex_hit));
  hazard_match u_rs_mem (.en(1'b1),       .src(IfIdRs), .dst(ExMemRd), .hit(rs_mem_hit));
  hazard_match u_rt_mem (.en(IfIdUsesRt), .src(IfIdRt), .dst(ExMemRd), .hit(rt_mem_hit));

  assign ex_hit  = rs_ex_hit  || rt_ex_hit;
  assign mem_hit = rs_mem_hit || rt_mem_hit;

  // Rules are applied in ascending order so the largest bubble count wins.
  always_comb begin
    need_bubbles = '0;
    if (IdExMemRead && ex_hit)
      need_bubbles = 2'd1;
    if (IfIdBranch && IdExRegWrite && !IdExMemRead && ex_hit)
      need_bubbles = 2'd1;
    if (IfIdBranch && ExMemMemRead && mem_hit)
      need_bubbles = 2'd1;
    if (IfIdBranch && IdExMemRead && ex_hit)
      need_bubbles = 2'd2;
  end

  // A stall suppresses the flush: the branch comparator operands are stale.
  always_comb begin
    PcWrite    = 1'b1;
    IfIdWrite  = 1'b1;
    IdExBubble = 1'b0;
    IfIdFlush  = 1'b0;
    if (rst) begin
      PcWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExBubble = 1'b1;
      IfIdFlush  = 1'b1;
    end else if (state_q == HOLD || need_bubbles != '0) begin
      PcWrite    = 1'b0;
      IfIdWrite  = 1'b0;
      IdExBubble = 1'b1;
    end else begin
      IfIdFlush  = IfIdBranch && BranchTaken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     state_q <= (need_bubbles == 2'd2) ? HOLD : RUN;
        HOLD:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PcWrite)  stall_cnt_q <= sat_inc(stall_cnt_q);
      if (IfIdFlush) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit; perf counter checks are
// compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IfIdRs, IfIdRt, IdExRd, ExMemRd;
  logic       IfIdUsesRt, IfIdBranch, IdExMemRead, IdExRegWrite;
  logic       ExMemMemRead, BranchTaken;
  logic       PcWrite, IfIdWrite, IfIdFlush, IdExBubble;
`ifdef HAZARD_PERF_EN
  logic [15:0] StallCycles, FlushCount;
`endif

  int checks = 0;
  int errors = 0;

  // {PcWrite, IfIdWrite, IdExBubble, IfIdFlush}
  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0010;
  localparam logic [3:0] O_FLUSH = 4'b1101;
  localparam logic [3:0] O_RST   = 4'b0011;

  logic [3:0] outs;
  assign outs = {PcWrite, IfIdWrite, IdExBubble, IfIdFlush};

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdUsesRt(IfIdUsesRt), .IfIdBranch(IfIdBranch),
    .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExRd(IdExRd),
    .ExMemMemRead(ExMemMemRead), .ExMemRd(ExMemRd), .BranchTaken(BranchTaken),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush), .IdExBubble(IdExBubble)
`ifdef HAZARD_PERF_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  // Advance to the next cycle's drive point and clear all pipeline inputs.
  task automatic next_cycle();
    @(negedge clk);
    IfIdRs = 5'd0; IfIdRt = 5'd0; IfIdUsesRt = 1'b0; IfIdBranch = 1'b0;
    IdExMemRead = 1'b0; IdExRegWrite = 1'b0; IdExRd = 5'd0;
    ExMemMemRead = 1'b0; ExMemRd = 5'd0; BranchTaken = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle(); rst = 1'b1;
    IdExMemRead = 1'b1; IdExRd = 5'd3; IfIdRs = 5'd3; #1;
    checks++; if (outs !== O_RST) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
    next_cycle(); rst = 1'b1; #1;
    checks++; if (outs !== O_RST) begin errors++; $display("FAIL reset_outs_idle: got %b want %b", outs, O_RST); end
    next_cycle(); rst = 1'b0; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL first_run: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_load_use();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd2; IfIdRs = 5'd2; IfIdRt = 5'd4; IfIdUsesRt = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL load_use_stall: got %b want %b", outs, O_STALL); end
    next_cycle(); ExMemMemRead = 1'b1; ExMemRd = 5'd2; IfIdRs = 5'd2; IfIdRt = 5'd4; IfIdUsesRt = 1'b1; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL load_use_resume: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_load_branch();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd5; IfIdBranch = 1'b1;
    IfIdRs = 5'd5; IfIdRt = 5'd1; IfIdUsesRt = 1'b1; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ldbr_stall1: got %b want %b", outs, O_STALL); end
    next_cycle(); ExMemMemRead = 1'b1; ExMemRd = 5'd5; IfIdBranch = 1'b1;
    IfIdRs = 5'd5; IfIdRt = 5'd1; IfIdUsesRt = 1'b1; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL ldbr_stall2: got %b want %b", outs, O_STALL); end
    next_cycle(); IfIdBranch = 1'b1; IfIdRs = 5'd5; IfIdRt = 5'd1; IfIdUsesRt = 1'b1; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL ldbr_flush: got %b want %b", outs, O_FLUSH); end
  endtask

  // HOLD must stall even when no detection rule fires on the second cycle.
  task automatic test_hold_ignores_inputs();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd6; IfIdBranch = 1'b1; IfIdRs = 5'd6; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL hold_enter: got %b want %b", outs, O_STALL); end
    next_cycle(); IfIdBranch = 1'b1; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL hold_stall: got %b want %b", outs, O_STALL); end
    next_cycle(); #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL hold_exit: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_alu_branch();
    next_cycle(); IdExRegWrite = 1'b1; IdExRd = 5'd7; IfIdBranch = 1'b1; IfIdRs = 5'd7; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL alubr_stall: got %b want %b", outs, O_STALL); end
    next_cycle(); IfIdBranch = 1'b1; IfIdRs = 5'd7; BranchTaken = 1'b1; #1;
    checks++; if (outs !== O_FLUSH) begin errors++; $display("FAIL alubr_flush: got %b want %b", outs, O_FLUSH); end
    next_cycle(); IfIdBranch = 1'b1; IfIdRs = 5'd7; BranchTaken = 1'b0; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL alubr_not_taken: got %b want %b", outs, O_RUN); end
    next_cycle(); IdExRegWrite = 1'b1; IdExRd = 5'd7; IfIdRs = 5'd7; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL alu_no_branch: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_mem_branch();
    next_cycle(); ExMemMemRead = 1'b1; ExMemRd = 5'd4; IfIdBranch = 1'b1;
    IfIdRs = 5'd8; IfIdRt = 5'd4; IfIdUsesRt = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL membr_stall: got %b want %b", outs, O_STALL); end
    next_cycle(); IfIdBranch = 1'b1; IfIdRs = 5'd8; IfIdRt = 5'd4; IfIdUsesRt = 1'b1; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL membr_resume: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_zero_reg();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd0; IfIdRs = 5'd0; IfIdBranch = 1'b1;
    ExMemMemRead = 1'b1; ExMemRd = 5'd0; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL zero_reg: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_uses_rt();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd9; IfIdRs = 5'd3; IfIdRt = 5'd9; IfIdUsesRt = 1'b0; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rt_unused: got %b want %b", outs, O_RUN); end
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd9; IfIdRs = 5'd3; IfIdRt = 5'd9; IfIdUsesRt = 1'b1; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL rt_used: got %b want %b", outs, O_STALL); end
  endtask

  task automatic test_rst_in_hold();
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd5; IfIdBranch = 1'b1; IfIdRs = 5'd5; #1;
    checks++; if (outs !== O_STALL) begin errors++; $display("FAIL rsthold_enter: got %b want %b", outs, O_STALL); end
    next_cycle(); rst = 1'b1; #1;
    checks++; if (outs !== O_RST) begin errors++; $display("FAIL rsthold_outs: got %b want %b", outs, O_RST); end
    next_cycle(); rst = 1'b0; #1;
    checks++; if (outs !== O_RUN) begin errors++; $display("FAIL rsthold_run: got %b want %b", outs, O_RUN); end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; #1;
    checks++; if (StallCycles !== 16'd0) begin errors++; $display("FAIL perf_stall_reset: got %0d want 0", StallCycles); end
    checks++; if (FlushCount !== 16'd0) begin errors++; $display("FAIL perf_flush_reset: got %0d want 0", FlushCount); end
    next_cycle(); IdExMemRead = 1'b1; IdExRd = 5'd5; IfIdBranch = 1'b1; IfIdRs = 5'd5;
    next_cycle(); ExMemMemRead = 1'b1; ExMemRd = 5'd5; IfIdBranch = 1'b1; IfIdRs = 5'd5;
    next_cycle(); IfIdBranch = 1'b1; IfIdRs = 5'd5; BranchTaken = 1'b1;
    next_cycle(); #1;
    checks++; if (StallCycles !== 16'd2) begin errors++; $display("FAIL perf_stall_count: got %0d want 2", StallCycles); end
    checks++; if (FlushCount !== 16'd1) begin errors++; $display("FAIL perf_flush_count: got %0d want 1", FlushCount); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_hold_ignores_inputs();
    test_alu_branch();
    test_mem_branch();
    test_zero_reg();
    test_uses_rt();
    test_rst_in_hold();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
